// File: rtl/edge_detector_pkg.sv
// Shared types and constants for the edge-detector window scanner and the
// downstream Sobel stage that consumes its window index.
package edge_detector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    localparam int WIN_TAPS  = 9;
    localparam int WIN_IDX_W = 4;

    localparam logic signed [1:0] OFF_NEG  = -2'sd1;
    localparam logic signed [1:0] OFF_ZERO = 2'sd0;
    localparam logic signed [1:0] OFF_POS  = 2'sd1;

endpackage

// File: rtl/edge_detector_window_scanner_if.sv
// Beat bus carrying one 3x3 neighbour coordinate plus centre/tap sideband
// from the window scanner to the address generator.
interface edge_detector_window_scanner_if #(
    parameter int X_BITS = 7,
    parameter int Y_BITS = 7
);
    import edge_detector_pkg::*;

    logic [X_BITS-1:0]    X_o;
    logic [Y_BITS-1:0]    Y_o;
    logic [X_BITS-1:0]    CenterX_o;
    logic [Y_BITS-1:0]    CenterY_o;
    logic [WIN_IDX_W-1:0] WinIdx_o;
    logic                 valid_o;
    logic                 ready_i;
    logic                 WinLast_o;
    logic                 FrameLast_o;

    modport master (
        output X_o, Y_o, CenterX_o, CenterY_o, WinIdx_o,
        output valid_o, WinLast_o, FrameLast_o,
        input  ready_i
    );

    modport slave (
        input  X_o, Y_o, CenterX_o, CenterY_o, WinIdx_o,
        input  valid_o, WinLast_o, FrameLast_o,
        output ready_i
    );

endinterface

// File: rtl/edge_detector_win_offset.sv
// Maps a 3x3 tap index k to its signed (dx, dy) offset: dx = k/3-1, dy = k%3-1.
// Shared with the Sobel weight lookup so both sides agree on tap order.
module edge_detector_win_offset
    import edge_detector_pkg::*;
(
    input  logic [WIN_IDX_W-1:0] k_i,
    output logic signed [1:0]    dx_o,
    output logic signed [1:0]    dy_o
);

    // Row offset: taps 0-2 left column, 3-5 centre, 6-8 right.
    always_comb begin
        dx_o = OFF_ZERO;
        case (k_i)
            4'd0, 4'd1, 4'd2: dx_o = OFF_NEG;
            4'd3, 4'd4, 4'd5: dx_o = OFF_ZERO;
            4'd6, 4'd7, 4'd8: dx_o = OFF_POS;
            default:          dx_o = OFF_ZERO;
        endcase
    end

    // Column offset cycles fastest within each row of taps.
    always_comb begin
        dy_o = OFF_ZERO;
        case (k_i)
            4'd0, 4'd3, 4'd6: dy_o = OFF_NEG;
            4'd1, 4'd4, 4'd7: dy_o = OFF_ZERO;
            4'd2, 4'd5, 4'd8: dy_o = OFF_POS;
            default:          dy_o = OFF_ZERO;
        endcase
    end

endmodule

// File: rtl/edge_detector_window_scanner.sv
// Walks every interior pixel of an X_SIZE x Y_SIZE image and streams the nine
// 3x3 neighbour coordinates of each over a valid/ready beat bus.
module edge_detector_window_scanner
    import edge_detector_pkg::*;
#(
    parameter int X_SIZE = 100,
    parameter int Y_SIZE = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    edge_detector_window_scanner_if.master win_if
);

    localparam int X_BITS = $clog2(X_SIZE);
    localparam int Y_BITS = $clog2(Y_SIZE);

    localparam logic [X_BITS-1:0]    X_ZERO  = X_BITS'(0);
    localparam logic [X_BITS-1:0]    X_FIRST = X_BITS'(1);
    localparam logic [X_BITS-1:0]    X_LAST  = X_BITS'(X_SIZE - 2);
    localparam logic [Y_BITS-1:0]    Y_ZERO  = Y_BITS'(0);
    localparam logic [Y_BITS-1:0]    Y_FIRST = Y_BITS'(1);
    localparam logic [Y_BITS-1:0]    Y_LAST  = Y_BITS'(Y_SIZE - 2);
    localparam logic [WIN_IDX_W-1:0] K_ZERO  = WIN_IDX_W'(0);
    localparam logic [WIN_IDX_W-1:0] K_LAST  = WIN_IDX_W'(WIN_TAPS - 1);

    scan_state_e          state_q, state_d;
    logic [X_BITS-1:0]    cx_q, cx_d;
    logic [Y_BITS-1:0]    cy_q, cy_d;
    logic [WIN_IDX_W-1:0] k_q, k_d;
    logic [X_BITS-1:0]    x_q, x_d;
    logic [Y_BITS-1:0]    y_q, y_d;
    logic                 valid_q, valid_d;
    logic                 win_last_q, win_last_d;
    logic                 frame_last_q, frame_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic signed [1:0]    dx_s;
    logic signed [1:0]    dy_s;
    logic                 xfer_s;

    // Offsets are looked up for the next beat so every output can be a flop.
    edge_detector_win_offset u_win_offset (
        .k_i  (k_d),
        .dx_o (dx_s),
        .dy_o (dy_s)
    );

    assign xfer_s = valid_q && win_if.ready_i;

    // Next-state and window/centre counter advance.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        k_d     = k_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SCAN;
                    cx_d    = X_FIRST;
                    cy_d    = Y_FIRST;
                    k_d     = K_ZERO;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                if (xfer_s) begin
                    if (frame_last_q) begin
                        state_d = ST_DONE;
                        cx_d    = X_ZERO;
                        cy_d    = Y_ZERO;
                        k_d     = K_ZERO;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else if (k_q != K_LAST) begin
                        k_d = k_q + WIN_IDX_W'(1);
                    end else begin
                        k_d = K_ZERO;
                        if (cy_q == Y_LAST) begin
                            cy_d = Y_FIRST;
                            cx_d = cx_q + X_BITS'(1);
                        end else begin
                            cy_d = cy_q + Y_BITS'(1);
                        end
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cx_d    = X_ZERO;
                cy_d    = Y_ZERO;
                k_d     = K_ZERO;
            end
        endcase
    end

    // Beat payload for the next cycle; centre plus offset never leaves the image.
    always_comb begin
        x_d          = X_ZERO;
        y_d          = Y_ZERO;
        win_last_d   = 1'b0;
        frame_last_d = 1'b0;
        if (valid_d) begin
            x_d          = cx_d + X_BITS'(dx_s);
            y_d          = cy_d + Y_BITS'(dy_s);
            win_last_d   = (k_d == K_LAST);
            frame_last_d = (k_d == K_LAST) && (cx_d == X_LAST) && (cy_d == Y_LAST);
        end else begin
            x_d          = X_ZERO;
            y_d          = Y_ZERO;
            win_last_d   = 1'b0;
            frame_last_d = 1'b0;
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cx_q         <= X_ZERO;
            cy_q         <= Y_ZERO;
            k_q          <= K_ZERO;
            x_q          <= X_ZERO;
            y_q          <= Y_ZERO;
            valid_q      <= 1'b0;
            win_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            k_q          <= k_d;
            x_q          <= x_d;
            y_q          <= y_d;
            valid_q      <= valid_d;
            win_last_q   <= win_last_d;
            frame_last_q <= frame_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign win_if.X_o         = x_q;
    assign win_if.Y_o         = y_q;
    assign win_if.CenterX_o   = cx_q;
    assign win_if.CenterY_o   = cy_q;
    assign win_if.WinIdx_o    = k_q;
    assign win_if.valid_o     = valid_q;
    assign win_if.WinLast_o   = win_last_q;
    assign win_if.FrameLast_o = frame_last_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

endmodule
